// File: rtl/fc8_sprite_engine.sv
// fc8_sprite_engine: per-scanline sprite evaluation, pattern fetch into a
// double-buffered line buffer, and per-pixel merge with the background index.
module fc8_sprite_engine #(
    parameter int          NUM_SPRITES      = 64,
    parameter int          MAX_PER_LINE     = 8,
    parameter logic [15:0] SPR_PATTERN_BASE = 16'hC000
) (
    input  logic        clk_pixel,
    input  logic        rst,
    input  logic [7:0]  oam_addr,
    input  logic [7:0]  oam_data,
    input  logic        oam_wr_en,
    input  logic        new_frame,
    input  logic        line_start,
    input  logic [7:0]  next_scanline_in,
    input  logic        pixel_active,
    input  logic [7:0]  h_coord_in,
    input  logic [7:0]  bg_color_index_in,
    output logic [15:0] spr_vram_addr_out,
    input  logic [7:0]  spr_vram_data_in,
    output logic [7:0]  sprite_final_pixel_color_out,
    output logic        sprite_overflow_out,
    output logic        busy_out
);

    localparam int unsigned    OAM_BYTES = NUM_SPRITES * 4;
    localparam int             IDX_W     = $clog2(NUM_SPRITES);
    localparam int             SLOT_W    = $clog2(MAX_PER_LINE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [SLOT_W:0]  MAX_CNT  = (SLOT_W + 1)'(MAX_PER_LINE);
    localparam logic [SLOT_W:0]  CNT_ONE  = (SLOT_W + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_FETCH} state_t;

    state_t            state;
    logic [7:0]        oam [OAM_BYTES];
    logic              oam_wr_ok;
    logic              disp_sel;          // 0: A displays, B fills
    logic [IDX_W-1:0]  eval_idx;
    logic [7:0]        eval_line;
    logic [SLOT_W:0]   slot_cnt;
    logic [2:0]        slot_row    [MAX_PER_LINE];
    logic [7:0]        slot_x      [MAX_PER_LINE];
    logic [7:0]        slot_tile   [MAX_PER_LINE];
    logic [3:0]        slot_pal    [MAX_PER_LINE];
    logic              slot_behind [MAX_PER_LINE];
    logic              slot_hflip  [MAX_PER_LINE];
    logic              slot_vflip  [MAX_PER_LINE];
    logic [SLOT_W-1:0] fetch_slot;
    logic [2:0]        fetch_col;
    logic [1:0]        drain;
    logic              m1_v, m2_v, m1_behind, m2_behind;
    logic [7:0]        m1_x, m2_x;
    logic [2:0]        m1_col, m2_col;
    logic [3:0]        m1_pal, m2_pal;
    logic [255:0]      lb_valid_a, lb_valid_b;
    logic [8:0]        lb_a [256];
    logic [8:0]        lb_b [256];

    logic [7:0]  ev_diff;
    logic        ev_hit;
    logic [2:0]  fr_row, fr_col;
    logic [15:0] fetch_addr;
    logic        last_issue;
    logic [3:0]  pix;
    logic [8:0]  fill_x9;
    logic        fill_we;
    logic        disp_valid;
    logic [8:0]  disp_ent;
    logic        unused_hi;

    if (OAM_BYTES >= 256) begin : g_oam_full
        always_comb oam_wr_ok = oam_wr_en;
    end else begin : g_oam_part
        always_comb oam_wr_ok = oam_wr_en && (int'(oam_addr) < int'(OAM_BYTES));
    end

    // OAM byte storage; CPU writes land on the edge, evaluation sees old data
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < OAM_BYTES; i++) oam[i] <= '0;
        end else if (oam_wr_ok) begin
            oam[oam_addr] <= oam_data;
        end
    end

    // Hit test, pattern address, fill-write qualification and display read
    always_comb begin
        ev_diff    = eval_line - oam[{eval_idx, 2'd0}];
        ev_hit     = (ev_diff[7:3] == 5'd0);
        fr_row     = slot_vflip[fetch_slot] ? ~slot_row[fetch_slot] : slot_row[fetch_slot];
        fr_col     = slot_hflip[fetch_slot] ? ~fetch_col : fetch_col;
        fetch_addr = SPR_PATTERN_BASE + {2'b00, slot_tile[fetch_slot], 6'b0}
                   + {10'b0, fr_row, fr_col};
        last_issue = (fetch_col == 3'd7) && ({1'b0, fetch_slot} == slot_cnt - CNT_ONE);
        pix        = spr_vram_data_in[3:0];
        unused_hi  = ^spr_vram_data_in[7:4];
        fill_x9    = {1'b0, m2_x} + {6'b0, m2_col};
        fill_we    = m2_v && (pix != 4'd0) && !fill_x9[8]
                   && !(disp_sel ? lb_valid_a[fill_x9[7:0]] : lb_valid_b[fill_x9[7:0]]);
        disp_valid = disp_sel ? lb_valid_b[h_coord_in] : lb_valid_a[h_coord_in];
        disp_ent   = disp_sel ? lb_b[h_coord_in] : lb_a[h_coord_in];
    end

    // Evaluation/fetch FSM with a two-stage tag pipeline aligned to VRAM data
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            busy_out            <= 1'b0;
            disp_sel            <= 1'b0;
            eval_idx            <= '0;
            eval_line           <= '0;
            slot_cnt            <= '0;
            fetch_slot          <= '0;
            fetch_col           <= '0;
            drain               <= '0;
            spr_vram_addr_out   <= '0;
            sprite_overflow_out <= 1'b0;
            {m1_v, m1_x, m1_col, m1_pal, m1_behind} <= '0;
            {m2_v, m2_x, m2_col, m2_pal, m2_behind} <= '0;
            for (int unsigned i = 0; i < MAX_PER_LINE; i++) begin
                slot_row[i]    <= '0;
                slot_x[i]      <= '0;
                slot_tile[i]   <= '0;
                slot_pal[i]    <= '0;
                slot_behind[i] <= 1'b0;
                slot_hflip[i]  <= 1'b0;
                slot_vflip[i]  <= 1'b0;
            end
        end else begin
            {m2_v, m2_x, m2_col, m2_pal, m2_behind} <= {m1_v, m1_x, m1_col, m1_pal, m1_behind};
            m1_v <= 1'b0;
            if (new_frame) sprite_overflow_out <= 1'b0;
            if (line_start) begin
                // Abort: in-flight fetches must not leak into the new fill buffer
                disp_sel          <= ~disp_sel;
                state             <= S_EVAL;
                busy_out          <= 1'b1;
                eval_idx          <= '0;
                eval_line         <= next_scanline_in;
                slot_cnt          <= '0;
                fetch_slot        <= '0;
                fetch_col         <= '0;
                drain             <= '0;
                spr_vram_addr_out <= '0;
                m2_v              <= 1'b0;
            end else begin
                case (state)
                    S_EVAL: begin
                        if (ev_hit) begin
                            if (slot_cnt < MAX_CNT) begin
                                slot_row[slot_cnt[SLOT_W-1:0]]    <= ev_diff[2:0];
                                slot_x[slot_cnt[SLOT_W-1:0]]      <= oam[{eval_idx, 2'd1}];
                                slot_tile[slot_cnt[SLOT_W-1:0]]   <= oam[{eval_idx, 2'd2}];
                                slot_pal[slot_cnt[SLOT_W-1:0]]    <= oam[{eval_idx, 2'd3}][3:0];
                                slot_behind[slot_cnt[SLOT_W-1:0]] <= oam[{eval_idx, 2'd3}][5];
                                slot_vflip[slot_cnt[SLOT_W-1:0]]  <= oam[{eval_idx, 2'd3}][6];
                                slot_hflip[slot_cnt[SLOT_W-1:0]]  <= oam[{eval_idx, 2'd3}][7];
                                slot_cnt <= slot_cnt + CNT_ONE;
                            end else begin
                                sprite_overflow_out <= 1'b1;
                            end
                        end
                        if (eval_idx == LAST_IDX) begin
                            if (slot_cnt != '0 || ev_hit) begin
                                state <= S_FETCH;
                            end else begin
                                state    <= S_IDLE;
                                busy_out <= 1'b0;
                            end
                        end else begin
                            eval_idx <= eval_idx + IDX_W'(1);
                        end
                    end
                    S_FETCH: begin
                        if (drain != 2'd0) begin
                            spr_vram_addr_out <= '0;
                            if (drain == 2'd2) begin
                                state    <= S_IDLE;
                                busy_out <= 1'b0;
                                drain    <= '0;
                            end else begin
                                drain <= 2'd2;
                            end
                        end else begin
                            spr_vram_addr_out <= fetch_addr;
                            m1_v      <= 1'b1;
                            m1_x      <= slot_x[fetch_slot];
                            m1_col    <= fetch_col;
                            m1_pal    <= slot_pal[fetch_slot];
                            m1_behind <= slot_behind[fetch_slot];
                            if (last_issue) begin
                                drain <= 2'd1;
                            end else if (fetch_col == 3'd7) begin
                                fetch_col  <= '0;
                                fetch_slot <= fetch_slot + SLOT_W'(1);
                            end else begin
                                fetch_col <= fetch_col + 3'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Valid bits: set by fill writes, cleared as the display side consumes them
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            lb_valid_a <= '0;
            lb_valid_b <= '0;
        end else begin
            if (fill_we) begin
                if (disp_sel) lb_valid_a[fill_x9[7:0]] <= 1'b1;
                else          lb_valid_b[fill_x9[7:0]] <= 1'b1;
            end
            if (pixel_active) begin
                if (disp_sel) lb_valid_b[h_coord_in] <= 1'b0;
                else          lb_valid_a[h_coord_in] <= 1'b0;
            end
        end
    end

    // Line buffer payload {behind, colour}; only meaningful where valid is set
    always_ff @(posedge clk_pixel) begin
        if (fill_we) begin
            if (disp_sel) lb_a[fill_x9[7:0]] <= {m2_behind, m2_pal, pix};
            else          lb_b[fill_x9[7:0]] <= {m2_behind, m2_pal, pix};
        end
    end

    // Registered priority merge of sprite and background colour
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            sprite_final_pixel_color_out <= '0;
        end else if (pixel_active) begin
            if (disp_valid && (!disp_ent[8] || bg_color_index_in[3:0] == 4'd0))
                sprite_final_pixel_color_out <= disp_ent[7:0];
            else
                sprite_final_pixel_color_out <= bg_color_index_in;
        end else begin
            sprite_final_pixel_color_out <= '0;
        end
    end

endmodule

// File: doc/fc8_sprite_engine.md
Name: fc8_sprite_engine

Overview:
- Per-scanline sprite renderer between the tile/bitmap fetch stage and the palette/VGA output stage.
- Evaluates sprite attribute memory (OAM) for the next scanline during the current one.
- Fetches sprite pattern bytes into a double-buffered line buffer.
- Each visible pixel, merges the sprite colour with the background colour index and delivers the final 8-bit colour index to the palette lookup.

Parameters:
NUM_SPRITES, 64, OAM entries; 4 bytes each: Y, X, TILE, ATTR
MAX_PER_LINE, 8, sprites rendered per scanline
SPR_PATTERN_BASE, 16'hC000, VRAM base of sprite patterns; 64 bytes per tile, 1 byte per pixel

Ports:
clk_pixel  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
oam_addr  in  8  OAM byte address; byte = index*4 + field
oam_data  in  8  OAM write data
oam_wr_en  in  1  OAM write strobe
new_frame  in  1  one-cycle pulse at frame start
line_start  in  1  one-cycle pulse at start of each line's horizontal blank
next_scanline_in  in  8  scanline (0-239) to prepare; sampled on line_start
pixel_active  in  1  current cycle is a visible pixel
h_coord_in  in  8  visible column of current pixel
bg_color_index_in  in  8  background colour index for current pixel
spr_vram_addr_out  out  16  sprite pattern read address
spr_vram_data_in  in  8  pattern data; valid one cycle after address
sprite_final_pixel_color_out  out  8  merged colour index to palette stage
sprite_overflow_out  out  1  sticky: more than MAX_PER_LINE sprites on a line this frame
busy_out  out  1  evaluation/fetch in progress

Behaviour:
- Reset: all outputs 0; FSM to IDLE; both line buffers invalid; slot count 0; OAM contents 0.
- OAM writes:
  - Write lands on the clock edge with oam_wr_en; addresses beyond NUM_SPRITES*4-1 are ignored.
  - Writes are allowed at any time. An evaluation reading the same entry in the same cycle sees the old value.
- Line buffers:
  - Two buffers A/B, 256 entries of {valid, behind, color[7:0]}.
  - On line_start the fill and display roles swap, and the FSM enters EVAL for next_scanline_in.
- FSM states and transitions:
  - IDLE: waits for line_start.
  - EVAL: one OAM entry per cycle, index 0..NUM_SPRITES-1.
    - Hit when (line - Y) mod 256 < 8; row = that difference.
    - The first MAX_PER_LINE hits are latched into slots in index order.
    - A further hit sets sprite_overflow_out.
    - After the last index: go to FETCH if count > 0, else IDLE.
  - FETCH: slots in order, columns 0..7, one address per cycle.
    - Address = SPR_PATTERN_BASE + TILE*64 + r*8 + c, where r = ATTR[6] ? 7-row : row and c = ATTR[7] ? 7-col : col.
    - Data returns the next cycle. pix = data[3:0].
    - Write to fill buffer at X+col when all three hold: pix != 0, X+col ≤ 255 (no horizontal wrap; 9-bit sum), and target entry not already valid.
    - Written value: {1, ATTR[5], ATTR[3:0], pix}. Lower OAM index therefore wins.
    - FETCH finishes one cycle after the last address, then returns to IDLE.
  - busy_out = 1 in EVAL and FETCH. Worst case 64 + 65 + 1 cycles, well inside a 341-cycle line.
- line_start while busy: the current operation aborts; the partially filled buffer is swapped to display as-is; EVAL restarts at index 0.
- Display path:
  - On a pixel_active cycle, read display buffer at h_coord_in and clear that entry (valid = 0) in the same cycle.
  - Output is registered, so latency is 1 cycle.
  - Output is the sprite colour if the entry is valid and (behind == 0 or bg_color_index_in[3:0] == 0); otherwise bg_color_index_in.
  - When pixel_active = 0, output 8'h00.
- new_frame clears sprite_overflow_out. If an overflow hit occurs in the same cycle, the set wins.
- Reset mid-operation: the FSM is forced to IDLE immediately and buffers are invalidated. spr_vram_addr_out holds 0 outside FETCH.

Test Plan:
1. OAM sprite 0 = {Y=10, X=20, TILE=1, ATTR=0x02}; pattern bytes = 0x05; line_start with next=12, then display line 12 -> columns 20-27 output 0x25 one cycle after pixel_active; columns 19 and 28 pass bg_color_index_in.
2. Same sprite with ATTR=0x82 and pattern row 2 = {1,2,3,4,5,6,7,8} -> column 20 shows 0x28, column 27 shows 0x21. ATTR=0x42 fetches row 5 instead of row 2.
3. Sprites 3 and 7 overlap at X=50 with ATTR palettes 1 and 2 -> overlapping columns show palette 1 (index 3 wins). Sprite 7 ATTR=0x22 over bg 0x05 shows 0x05; over bg 0x10 shows sprite colour.
4. Nine sprites on line 100 -> first eight (lowest indices) rendered; sprite_overflow_out = 1 after EVAL; new_frame clears it to 0.
5. Sprite X=252 -> only columns 252-255 written, no write at column 0. Sprite Y=250 on line 2 -> row 8 mod 256 rejected; Y=252 on line 2 -> row 6 rendered.
6. line_start re-asserted mid-FETCH -> EVAL restarts at index 0, busy_out stays 1. rst pulsed mid-EVAL -> busy_out = 0 and output 0x00 next cycle; the subsequent line shows no sprites.
